// File: rtl/pgm_pkg.sv
// Shared definitions for the packet-generator checker: packet type codes,
// config-chain opcodes, register map and the latency histogram binning helper.
// The optional latency histogram is built only when PGM_CHK_HIST_EN is defined.
package pgm_pkg;

    localparam logic [1:0] PKT_HEAD = 2'b01;
    localparam logic [1:0] PKT_BODY = 2'b11;
    localparam logic [1:0] PKT_TAIL = 2'b10;

    localparam logic [2:0] CFG_WR  = 3'b010;
    localparam logic [2:0] CFG_RD  = 3'b001;
    localparam logic [3:0] CFG_RSP = 4'b1011;

    localparam logic [31:0] TAG_MAGIC = 32'hFFFF_FFFF;

    localparam logic [31:0] ADDR_CLR       = 32'h0000_0000;
    localparam logic [31:0] ADDR_EN        = 32'h0002_0000;
    localparam logic [31:0] ADDR_RX_LO     = 32'h0002_0001;
    localparam logic [31:0] ADDR_RX_HI     = 32'h0002_0002;
    localparam logic [31:0] ADDR_TAG_LO    = 32'h0002_0003;
    localparam logic [31:0] ADDR_TAG_HI    = 32'h0002_0004;
    localparam logic [31:0] ADDR_LOST_LO   = 32'h0002_0005;
    localparam logic [31:0] ADDR_LOST_HI   = 32'h0002_0006;
    localparam logic [31:0] ADDR_OOO       = 32'h0002_0007;
    localparam logic [31:0] ADDR_LAT_MIN   = 32'h0002_0008;
    localparam logic [31:0] ADDR_LAT_MAX   = 32'h0002_0009;
    localparam logic [31:0] ADDR_SUM_LO    = 32'h0002_000A;
    localparam logic [31:0] ADDR_SUM_HI    = 32'h0002_000B;
    localparam logic [31:0] ADDR_LAST_LAT  = 32'h0002_000C;
    localparam logic [31:0] ADDR_STATE     = 32'h0002_000D;
    localparam logic [31:0] ADDR_HIST_BASE = 32'h0002_0010;

    localparam int HIST_SHIFT = 4;
    localparam int HIST_BINS  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } parse_state_t;

    // Latencies beyond the last bin's range all pile into bin 7.
    function automatic logic [2:0] hist_bin(input logic [31:0] lat);
        return (lat[31:HIST_SHIFT+3] == '0) ? lat[HIST_SHIFT+2:HIST_SHIFT] : 3'd7;
    endfunction

endpackage

// File: rtl/pgm_chk_stats.sv
// Loss / reorder / latency accumulators for pgm_chk with a combinational read
// mux. Histogram bins exist only when PGM_CHK_HIST_EN is defined.
module pgm_chk_stats
    import pgm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        upd,
    input  logic        clr,
    input  logic        en,
    input  logic        tag_hit,
    input  logic [63:0] seq,
    input  logic [31:0] lat,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data
);

    logic [63:0] rx_pkt_cnt_reg;
    logic [63:0] tag_cnt_reg;
    logic [63:0] lost_cnt_reg;
    logic [63:0] lat_sum_reg;
    logic [63:0] expected_reg;
    logic [31:0] ooo_cnt_reg;
    logic [31:0] lat_min_reg;
    logic [31:0] lat_max_reg;
    logic [31:0] last_lat_reg;
    logic        seen_reg;

    // Clear beats a same-cycle update; disabled checker leaves every stat frozen.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rx_pkt_cnt_reg <= '0;
            tag_cnt_reg    <= '0;
            lost_cnt_reg   <= '0;
            lat_sum_reg    <= '0;
            expected_reg   <= '0;
            ooo_cnt_reg    <= '0;
            lat_min_reg    <= 32'hFFFF_FFFF;
            lat_max_reg    <= '0;
            last_lat_reg   <= '0;
            seen_reg       <= 1'b0;
        end else if (upd && en) begin
            rx_pkt_cnt_reg <= rx_pkt_cnt_reg + 64'd1;
            if (tag_hit) begin
                tag_cnt_reg  <= tag_cnt_reg + 64'd1;
                last_lat_reg <= lat;
                lat_sum_reg  <= lat_sum_reg + {32'h0, lat};
                if (lat < lat_min_reg) lat_min_reg <= lat;
                if (lat > lat_max_reg) lat_max_reg <= lat;
                if (!seen_reg) begin
                    seen_reg     <= 1'b1;
                    expected_reg <= seq + 64'd1;
                end else if (seq == expected_reg) begin
                    expected_reg <= expected_reg + 64'd1;
                end else if (seq > expected_reg) begin
                    lost_cnt_reg <= lost_cnt_reg + (seq - expected_reg);
                    expected_reg <= seq + 64'd1;
                end else begin
                    ooo_cnt_reg <= ooo_cnt_reg + 32'd1;
                end
            end
        end
    end

`ifdef PGM_CHK_HIST_EN
    logic [2:0]  bin_idx;
    logic [31:0] hist_view [HIST_BINS];

    assign bin_idx = hist_bin(lat);

    genvar gi;
    generate
        for (gi = 0; gi < HIST_BINS; gi++) begin : g_hist
            logic [31:0] cnt_reg;
            // One saturating counter per latency bin, counting tagged packets only.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    cnt_reg <= '0;
                end else if (upd && en && tag_hit && (bin_idx == 3'(gi)) &&
                             (cnt_reg != 32'hFFFF_FFFF)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
            assign hist_view[gi] = cnt_reg;
        end
    endgenerate
`endif

    // Register read mux; anything unmapped reads as all ones.
    always_comb begin
        rd_data = 32'hFFFF_FFFF;
        case (rd_addr)
            ADDR_RX_LO:    rd_data = rx_pkt_cnt_reg[31:0];
            ADDR_RX_HI:    rd_data = rx_pkt_cnt_reg[63:32];
            ADDR_TAG_LO:   rd_data = tag_cnt_reg[31:0];
            ADDR_TAG_HI:   rd_data = tag_cnt_reg[63:32];
            ADDR_LOST_LO:  rd_data = lost_cnt_reg[31:0];
            ADDR_LOST_HI:  rd_data = lost_cnt_reg[63:32];
            ADDR_OOO:      rd_data = ooo_cnt_reg;
            ADDR_LAT_MIN:  rd_data = lat_min_reg;
            ADDR_LAT_MAX:  rd_data = lat_max_reg;
            ADDR_SUM_LO:   rd_data = lat_sum_reg[31:0];
            ADDR_SUM_HI:   rd_data = lat_sum_reg[63:32];
            ADDR_LAST_LAT: rd_data = last_lat_reg;
            default:       rd_data = 32'hFFFF_FFFF;
        endcase
`ifdef PGM_CHK_HIST_EN
        if (rd_addr[31:3] == ADDR_HIST_BASE[31:3]) rd_data = hist_view[rd_addr[2:0]];
`endif
    end

endmodule

// File: rtl/pgm_chk.sv
// Receive-side checker for packet-generator traffic: one-cycle datapath
// pass-through, tag-word parser, statistics, and config-chain register access.
// Define PGM_CHK_HIST_EN to add the 8-bin latency histogram.
module pgm_chk
    import pgm_pkg::*;
#(
    parameter logic [7:0]  LMID      = 8'd63,
    parameter logic [3:0]  TAG_IDX   = 4'd5,
    parameter logic [31:0] TAG_MAGIC = pgm_pkg::TAG_MAGIC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [133:0]  in_chk_data,
    input  logic          in_chk_data_wr,
    input  logic          in_chk_valid,
    input  logic          in_chk_valid_wr,
    input  logic [1023:0] in_chk_phv,
    input  logic          in_chk_phv_wr,
    output logic          out_chk_alf,
    output logic          out_chk_phv_alf,
    output logic [133:0]  out_chk_data,
    output logic          out_chk_data_wr,
    output logic          out_chk_valid,
    output logic          out_chk_valid_wr,
    output logic [1023:0] out_chk_phv,
    output logic          out_chk_phv_wr,
    input  logic          in_chk_alf,
    input  logic          in_chk_phv_alf,
    input  logic [31:0]   timestamp2chk,
    input  logic [133:0]  cin_chk_data,
    input  logic          cin_chk_data_wr,
    output logic          cout_chk_ready,
    output logic [133:0]  cout_chk_data,
    output logic          cout_chk_data_wr,
    input  logic          cin_chk_ready
);

    parse_state_t state_reg;
    logic [3:0]   word_idx_reg;
    logic         tag_hit_reg;
    logic [63:0]  seq_reg;
    logic [31:0]  lat_reg;
    logic         chk_en_reg;
    logic         drop_reg;

    logic [1:0]   in_type;
    logic         tag_now;
    logic [31:0]  lat_now;
    logic         upd;
    logic         upd_tag;
    logic [63:0]  upd_seq;
    logic [31:0]  upd_lat;

    logic [1:0]   c_type;
    logic         c_head;
    logic         c_is_wr;
    logic         c_is_rd;
    logic [31:0]  c_addr;
    logic         soft_clr;
    logic [31:0]  stats_rd_data;
    logic [31:0]  rd_data;
    logic [133:0] rsp_word;

    assign out_chk_alf     = in_chk_alf;
    assign out_chk_phv_alf = in_chk_phv_alf;
    assign cout_chk_ready  = cin_chk_ready;

    // Datapath: plain one-cycle register stage, contents untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_chk_data     <= '0;
            out_chk_data_wr  <= 1'b0;
            out_chk_valid    <= 1'b0;
            out_chk_valid_wr <= 1'b0;
            out_chk_phv      <= '0;
            out_chk_phv_wr   <= 1'b0;
        end else begin
            out_chk_data     <= in_chk_data;
            out_chk_data_wr  <= in_chk_data_wr;
            out_chk_valid    <= in_chk_valid;
            out_chk_valid_wr <= in_chk_valid_wr;
            out_chk_phv      <= in_chk_phv;
            out_chk_phv_wr   <= in_chk_phv_wr;
        end
    end

    // The word being accepted now has index word_idx_reg+1; a tail landing on
    // the tag index still counts as tagged.
    assign in_type = in_chk_data[133:132];
    assign lat_now = timestamp2chk - in_chk_data[63:32];
    assign tag_now = in_chk_data_wr && (state_reg == ST_BODY) && (in_type != PKT_HEAD) &&
                     (word_idx_reg + 4'd1 == TAG_IDX) && (in_chk_data[31:0] == TAG_MAGIC);
    assign upd     = in_chk_data_wr && (state_reg == ST_BODY) &&
                     ((in_type == PKT_TAIL) || (in_type == PKT_HEAD));
    assign upd_tag = (in_type == PKT_TAIL) && (tag_hit_reg || tag_now);
    assign upd_seq = tag_now ? in_chk_data[127:64] : seq_reg;
    assign upd_lat = tag_now ? lat_now : lat_reg;

    // Parser: tracks word position within a packet and captures the tag word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            word_idx_reg <= '0;
            tag_hit_reg  <= 1'b0;
            seq_reg      <= '0;
            lat_reg      <= '0;
        end else if (in_chk_data_wr) begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_type == PKT_HEAD) begin
                        word_idx_reg <= '0;
                        tag_hit_reg  <= 1'b0;
                        state_reg    <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (in_type == PKT_HEAD) begin
                        word_idx_reg <= '0;
                        tag_hit_reg  <= 1'b0;
                    end else begin
                        if (word_idx_reg != 4'hF) word_idx_reg <= word_idx_reg + 4'd1;
                        if (tag_now) begin
                            tag_hit_reg <= 1'b1;
                            seq_reg     <= in_chk_data[127:64];
                            lat_reg     <= lat_now;
                        end
                        if (in_type == PKT_TAIL) state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Config decode: only head words addressed to this block are acted on.
    assign c_type   = cin_chk_data[133:132];
    assign c_head   = cin_chk_data_wr && (c_type == PKT_HEAD) && (cin_chk_data[103:96] == LMID);
    assign c_is_wr  = c_head && (cin_chk_data[126:124] == CFG_WR);
    assign c_is_rd  = c_head && (cin_chk_data[126:124] == CFG_RD);
    assign c_addr   = cin_chk_data[95:64];
    assign soft_clr = c_is_wr && (c_addr == ADDR_CLR) && cin_chk_data[0];
    assign rd_data  = (c_addr == ADDR_STATE) ? {31'h0, state_reg} : stats_rd_data;
    assign rsp_word = {cin_chk_data[133:128], CFG_RSP, cin_chk_data[123:112],
                       cin_chk_data[103:96], cin_chk_data[111:104], cin_chk_data[95:32], rd_data};

    // Config chain: answer reads in place, swallow writes through their tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            cout_chk_data    <= '0;
            cout_chk_data_wr <= 1'b0;
            chk_en_reg       <= 1'b1;
            drop_reg         <= 1'b0;
        end else begin
            cout_chk_data    <= c_is_rd ? rsp_word : cin_chk_data;
            cout_chk_data_wr <= cin_chk_data_wr && !c_is_wr && !drop_reg;
            if (c_is_wr && (c_addr == ADDR_EN)) chk_en_reg <= cin_chk_data[0];
            if (c_is_wr) begin
                drop_reg <= 1'b1;
            end else if (cin_chk_data_wr && drop_reg && (c_type == PKT_TAIL)) begin
                drop_reg <= 1'b0;
            end
        end
    end

    pgm_chk_stats u_stats (
        .clk     (clk),
        .rst     (rst),
        .upd     (upd),
        .clr     (soft_clr),
        .en      (chk_en_reg),
        .tag_hit (upd_tag),
        .seq     (upd_seq),
        .lat     (upd_lat),
        .rd_addr (c_addr),
        .rd_data (stats_rd_data)
    );

endmodule

// File: tb/tb_pgm_chk.sv
// Directed bench for pgm_chk: register-read expectation tables per phase plus
// hand-written sequences for restart, clear collision and parser state.
module tb_pgm_chk;
    import pgm_pkg::*;

    localparam logic [7:0] LMID    = 8'd63;
    localparam logic [7:0] SRC_MID = 8'h11;
    localparam int         TAGW    = 5;

`ifdef PGM_CHK_HIST_EN
    localparam logic [31:0] EXP_BIN0 = 32'd0;
    localparam logic [31:0] EXP_BIN1 = 32'd1;
`else
    localparam logic [31:0] EXP_BIN0 = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_BIN1 = 32'hFFFF_FFFF;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [133:0]  in_chk_data;
    logic          in_chk_data_wr;
    logic          in_chk_valid;
    logic          in_chk_valid_wr;
    logic [1023:0] in_chk_phv;
    logic          in_chk_phv_wr;
    logic          out_chk_alf;
    logic          out_chk_phv_alf;
    logic [133:0]  out_chk_data;
    logic          out_chk_data_wr;
    logic          out_chk_valid;
    logic          out_chk_valid_wr;
    logic [1023:0] out_chk_phv;
    logic          out_chk_phv_wr;
    logic          in_chk_alf;
    logic          in_chk_phv_alf;
    logic [31:0]   timestamp2chk;
    logic [133:0]  cin_chk_data;
    logic          cin_chk_data_wr;
    logic          cout_chk_ready;
    logic [133:0]  cout_chk_data;
    logic          cout_chk_data_wr;
    logic          cin_chk_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          phase;
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    rd_vec_t tbl[$];

    always #5 clk = ~clk;

    pgm_chk dut (
        .clk              (clk),
        .rst              (rst),
        .in_chk_data      (in_chk_data),
        .in_chk_data_wr   (in_chk_data_wr),
        .in_chk_valid     (in_chk_valid),
        .in_chk_valid_wr  (in_chk_valid_wr),
        .in_chk_phv       (in_chk_phv),
        .in_chk_phv_wr    (in_chk_phv_wr),
        .out_chk_alf      (out_chk_alf),
        .out_chk_phv_alf  (out_chk_phv_alf),
        .out_chk_data     (out_chk_data),
        .out_chk_data_wr  (out_chk_data_wr),
        .out_chk_valid    (out_chk_valid),
        .out_chk_valid_wr (out_chk_valid_wr),
        .out_chk_phv      (out_chk_phv),
        .out_chk_phv_wr   (out_chk_phv_wr),
        .in_chk_alf       (in_chk_alf),
        .in_chk_phv_alf   (in_chk_phv_alf),
        .timestamp2chk    (timestamp2chk),
        .cin_chk_data     (cin_chk_data),
        .cin_chk_data_wr  (cin_chk_data_wr),
        .cout_chk_ready   (cout_chk_ready),
        .cout_chk_data    (cout_chk_data),
        .cout_chk_data_wr (cout_chk_data_wr),
        .cin_chk_ready    (cin_chk_ready)
    );

    function automatic void add(input int p, input logic [31:0] a, input logic [31:0] e,
                                input string n);
        rd_vec_t v;
        v.phase = p;
        v.addr  = a;
        v.exp   = e;
        v.name  = n;
        tbl.push_back(v);
    endfunction

    function automatic logic [133:0] pkt_word(input logic [1:0] t, input logic [127:0] d);
        return {t, 4'hF, d};
    endfunction

    function automatic logic [133:0] cfg_word(input logic [3:0] op, input logic [7:0] src,
                                              input logic [7:0] dst, input logic [31:0] addr,
                                              input logic [31:0] data);
        return {PKT_HEAD, 4'hF, op, 12'h000, src, dst, addr, 32'h0, data};
    endfunction

    function automatic logic [133:0] cfg_tail();
        return {PKT_TAIL, 4'hF, 128'h0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // Drives one datapath word for a cycle and checks it reappears one cycle later.
    task automatic send_word(input logic [133:0] w);
        logic [1023:0] phv_e;
        logic          vwr;
        logic          pwr;
        for (int k = 0; k < 32; k++) phv_e[k*32 +: 32] = $urandom();
        pwr             = (w[133:132] == PKT_HEAD);
        vwr             = (w[133:132] == PKT_TAIL);
        in_chk_data     = w;
        in_chk_data_wr  = 1'b1;
        in_chk_phv      = phv_e;
        in_chk_phv_wr   = pwr;
        in_chk_valid    = 1'b1;
        in_chk_valid_wr = vwr;
        @(negedge clk);
        checks++;
        if ({out_chk_data_wr, out_chk_data, out_chk_valid, out_chk_valid_wr, out_chk_phv_wr} !==
            {1'b1, w, 1'b1, vwr, pwr} || (pwr && out_chk_phv !== phv_e)) begin
            errors++;
            $display("FAIL datapath: got wr=%b data=%h expected wr=1 data=%h",
                     out_chk_data_wr, out_chk_data, w);
        end
        in_chk_data_wr  = 1'b0;
        in_chk_phv_wr   = 1'b0;
        in_chk_valid_wr = 1'b0;
    endtask

    task automatic send_pkt(input int nwords, input logic [63:0] seq, input logic [31:0] tx,
                            input logic [31:0] magic);
        logic [1:0]   t;
        logic [127:0] d;
        for (int i = 0; i < nwords; i++) begin
            t = (i == 0) ? PKT_HEAD : ((i == nwords - 1) ? PKT_TAIL : PKT_BODY);
            d = (i == TAGW) ? {seq, tx, magic} : {96'h0, 32'(i)};
            send_word(pkt_word(t, d));
        end
        $display("pkt  words=%0d seq=%0d tx=%h ts=%h", nwords, seq, tx, timestamp2chk);
    endtask

    task automatic cfg_read(input logic [31:0] addr, output logic [31:0] data);
        logic [133:0] exp_hdr;
        logic [133:0] tw;
        cin_chk_data    = cfg_word({1'b0, CFG_RD}, SRC_MID, LMID, addr, 32'h0);
        cin_chk_data_wr = 1'b1;
        @(negedge clk);
        exp_hdr = cfg_word(CFG_RSP, LMID, SRC_MID, addr, 32'h0);
        checks++;
        if (!cout_chk_data_wr || cout_chk_data[133:32] !== exp_hdr[133:32]) begin
            errors++;
            $display("FAIL rsp_hdr: got wr=%b hdr=%h expected wr=1 hdr=%h",
                     cout_chk_data_wr, cout_chk_data[133:32], exp_hdr[133:32]);
        end
        data = cout_chk_data[31:0];
        tw              = cfg_tail();
        cin_chk_data    = tw;
        @(negedge clk);
        checks++;
        if (!cout_chk_data_wr || cout_chk_data !== tw) begin
            errors++;
            $display("FAIL rsp_tail: got wr=%b data=%h expected wr=1 data=%h",
                     cout_chk_data_wr, cout_chk_data, tw);
        end
        cin_chk_data_wr = 1'b0;
    endtask

    task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
        cin_chk_data    = cfg_word({1'b0, CFG_WR}, SRC_MID, LMID, addr, data);
        cin_chk_data_wr = 1'b1;
        @(negedge clk);
        chk("wr_head_dropped", {63'h0, cout_chk_data_wr}, 64'h0);
        cin_chk_data = cfg_tail();
        @(negedge clk);
        chk("wr_tail_dropped", {63'h0, cout_chk_data_wr}, 64'h0);
        cin_chk_data_wr = 1'b0;
    endtask

    task automatic run_phase(input int p);
        logic [31:0] d;
        foreach (tbl[i]) begin
            if (tbl[i].phase == p) begin
                cfg_read(tbl[i].addr, d);
                chk($sformatf("p%0d_%s", p, tbl[i].name), {32'h0, d}, {32'h0, tbl[i].exp});
            end
        end
    endtask

    initial begin
        logic [31:0]  d;
        logic [133:0] w;

        add(0, ADDR_RX_LO,    32'd0,          "rx_lo");
        add(0, ADDR_TAG_LO,   32'd0,          "tag_lo");
        add(0, ADDR_LAT_MIN,  32'hFFFF_FFFF,  "lat_min");
        add(0, ADDR_LAT_MAX,  32'd0,          "lat_max");
        add(0, ADDR_OOO,      32'd0,          "ooo");
        add(0, ADDR_STATE,    32'd0,          "state");
        add(1, ADDR_RX_LO,    32'd3,          "rx_lo");
        add(1, ADDR_RX_HI,    32'd0,          "rx_hi");
        add(1, ADDR_TAG_LO,   32'd3,          "tag_lo");
        add(1, ADDR_LOST_LO,  32'd0,          "lost_lo");
        add(1, ADDR_OOO,      32'd0,          "ooo");
        add(1, ADDR_LAT_MIN,  32'd100,        "lat_min");
        add(1, ADDR_LAT_MAX,  32'd100,        "lat_max");
        add(1, ADDR_SUM_LO,   32'd300,        "sum_lo");
        add(1, ADDR_LAST_LAT, 32'd100,        "last_lat");
        add(2, ADDR_RX_LO,    32'd5,          "rx_lo");
        add(2, ADDR_TAG_LO,   32'd5,          "tag_lo");
        add(2, ADDR_LOST_LO,  32'd3,          "lost_lo");
        add(2, ADDR_LOST_HI,  32'd0,          "lost_hi");
        add(2, ADDR_OOO,      32'd1,          "ooo");
        add(2, ADDR_LAT_MIN,  32'd10,         "lat_min");
        add(2, ADDR_LAT_MAX,  32'd50,         "lat_max");
        add(2, ADDR_SUM_LO,   32'd150,        "sum_lo");
        add(2, ADDR_LAST_LAT, 32'd50,         "last_lat");
        add(3, ADDR_RX_LO,    32'd2,          "rx_lo");
        add(3, ADDR_TAG_LO,   32'd0,          "tag_lo");
        add(3, ADDR_LAT_MIN,  32'hFFFF_FFFF,  "lat_min");
        add(3, ADDR_SUM_LO,   32'd0,          "sum_lo");
        add(4, ADDR_RX_LO,    32'd2,          "rx_lo");
        add(4, ADDR_TAG_LO,   32'd1,          "tag_lo");
        add(4, ADDR_LAST_LAT, 32'd32,         "last_lat");
        add(4, ADDR_LAT_MIN,  32'd32,         "lat_min");
        add(4, ADDR_SUM_LO,   32'd32,         "sum_lo");
        add(4, ADDR_SUM_HI,   32'd0,          "sum_hi");
        add(4, ADDR_LOST_LO,  32'd0,          "lost_lo");
        add(5, ADDR_RX_LO,    32'd0,          "rx_lo");
        add(5, ADDR_TAG_LO,   32'd0,          "tag_lo");
        add(5, ADDR_LOST_LO,  32'd0,          "lost_lo");
        add(5, ADDR_LAT_MIN,  32'hFFFF_FFFF,  "lat_min");
        add(5, ADDR_LAT_MAX,  32'd0,          "lat_max");
        add(5, ADDR_SUM_LO,   32'd0,          "sum_lo");
        add(5, ADDR_LAST_LAT, 32'd0,          "last_lat");
        add(6, ADDR_RX_LO,    32'd0,          "rx_lo");
        add(6, ADDR_TAG_LO,   32'd0,          "tag_lo");
        add(6, ADDR_LAST_LAT, 32'd0,          "last_lat");
        add(7, ADDR_RX_LO,    32'd1,          "rx_lo");
        add(7, ADDR_TAG_LO,   32'd1,          "tag_lo");
        add(7, ADDR_LAST_LAT, 32'd20,         "last_lat");
        add(7, ADDR_LAT_MIN,  32'd20,         "lat_min");
        add(7, 32'h0002_0010, EXP_BIN0,       "hist0");
        add(7, 32'h0002_0011, EXP_BIN1,       "hist1");
        add(7, 32'h0002_0017, EXP_BIN0,       "hist7");
        add(7, 32'h0002_0018, 32'hFFFF_FFFF,  "unmapped18");
        add(7, 32'h0002_0020, 32'hFFFF_FFFF,  "unmapped20");

        rst             = 1'b1;
        in_chk_data     = '0;
        in_chk_data_wr  = 1'b0;
        in_chk_valid    = 1'b0;
        in_chk_valid_wr = 1'b0;
        in_chk_phv      = '0;
        in_chk_phv_wr   = 1'b0;
        in_chk_alf      = 1'b0;
        in_chk_phv_alf  = 1'b0;
        timestamp2chk   = '0;
        cin_chk_data    = '0;
        cin_chk_data_wr = 1'b0;
        cin_chk_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state and combinational flow-control copies
        chk("rst_out_wr", {63'h0, out_chk_data_wr}, 64'h0);
        chk("rst_cout_wr", {63'h0, cout_chk_data_wr}, 64'h0);
        chk("rst_out_data_lo", out_chk_data[63:0], 64'h0);
        in_chk_alf    = 1'b1;
        cin_chk_ready = 1'b1;
        #1;
        chk("alf_copy", {61'h0, out_chk_alf, out_chk_phv_alf, cout_chk_ready}, 64'h5);
        in_chk_alf     = 1'b0;
        in_chk_phv_alf = 1'b1;
        cin_chk_ready  = 1'b0;
        #1;
        chk("phv_alf_copy", {61'h0, out_chk_alf, out_chk_phv_alf, cout_chk_ready}, 64'h2);
        in_chk_phv_alf = 1'b0;
        @(negedge clk);
        run_phase(0);

        // Three in-order tagged packets, latency 100
        timestamp2chk = 32'd1000;
        for (int s = 0; s < 3; s++) send_pkt(8, 64'(s), 32'd900, TAG_MAGIC);
        run_phase(1);

        // Loss and reorder: seq 0,1,5,3 then 6 proves expected advanced to 6
        cfg_write(ADDR_CLR, 32'h1);
        timestamp2chk = 32'd2000;
        begin
            logic [63:0] seqs [5];
            seqs = '{64'd0, 64'd1, 64'd5, 64'd3, 64'd6};
            for (int k = 0; k < 5; k++)
                send_pkt(8, seqs[k], 32'd2000 - 32'(10 * (k + 1)), TAG_MAGIC);
        end
        run_phase(2);

        // Untagged: short packet, and wrong magic at the tag index
        cfg_write(ADDR_CLR, 32'h1);
        send_pkt(4, 64'd0, 32'd0, TAG_MAGIC);
        send_pkt(8, 64'd4, 32'd0, 32'h1234_5678);
        run_phase(3);

        // Aborted packet restarted by a new head, then a wrapping timestamp
        cfg_write(ADDR_CLR, 32'h1);
        timestamp2chk = 32'h0000_0010;
        send_word(pkt_word(PKT_HEAD, 128'h0));
        send_word(pkt_word(PKT_BODY, 128'h1));
        send_word(pkt_word(PKT_BODY, 128'h2));
        send_pkt(8, 64'd9, 32'hFFFF_FFF0, TAG_MAGIC);
        run_phase(4);

        // Soft clear arrives in the same cycle as a tagged tail
        timestamp2chk = 32'd3000;
        for (int i = 0; i < 7; i++)
            send_word(pkt_word((i == 0) ? PKT_HEAD : PKT_BODY,
                               (i == TAGW) ? {64'd10, 32'd2990, TAG_MAGIC} : 128'h0));
        in_chk_data     = pkt_word(PKT_TAIL, 128'h0);
        in_chk_data_wr  = 1'b1;
        cin_chk_data    = cfg_word({1'b0, CFG_WR}, SRC_MID, LMID, ADDR_CLR, 32'h1);
        cin_chk_data_wr = 1'b1;
        @(negedge clk);
        chk("p5_clr_head_dropped", {63'h0, cout_chk_data_wr}, 64'h0);
        chk("p5_tail_forwarded", {63'h0, out_chk_data_wr}, 64'h1);
        in_chk_data_wr = 1'b0;
        cin_chk_data   = cfg_tail();
        @(negedge clk);
        chk("p5_clr_tail_dropped", {63'h0, cout_chk_data_wr}, 64'h0);
        // A read for another block goes through untouched
        w               = cfg_word({1'b0, CFG_RD}, SRC_MID, 8'd5, ADDR_RX_LO, 32'hABCD);
        cin_chk_data    = w;
        @(negedge clk);
        checks++;
        if (!cout_chk_data_wr || cout_chk_data !== w) begin
            errors++;
            $display("FAIL cfg_passthru: got wr=%b data=%h expected wr=1 data=%h",
                     cout_chk_data_wr, cout_chk_data, w);
        end
        cin_chk_data_wr = 1'b0;
        run_phase(5);

        // Disabled checker: datapath forwards, stats frozen
        cfg_write(ADDR_EN, 32'h0);
        timestamp2chk = 32'd500;
        send_pkt(8, 64'd100, 32'd480, TAG_MAGIC);
        send_pkt(8, 64'd101, 32'd480, TAG_MAGIC);
        run_phase(6);

        // Re-enabled: one packet with latency 20 lands in histogram bin 1
        cfg_write(ADDR_EN, 32'h1);
        send_pkt(8, 64'd200, 32'd480, TAG_MAGIC);
        run_phase(7);

        // Parser state visible mid-packet
        send_word(pkt_word(PKT_HEAD, 128'h0));
        cfg_read(ADDR_STATE, d);
        chk("state_in_body", {32'h0, d}, 64'h1);
        send_word(pkt_word(PKT_TAIL, 128'h0));
        cfg_read(ADDR_STATE, d);
        chk("state_after_tail", {32'h0, d}, 64'h0);
        cfg_read(ADDR_RX_LO, d);
        chk("rx_after_short", {32'h0, d}, 64'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
